// File: rtl/rvc_pkg.sv
// Shared rvc helpers: width math used by every rvc block that exposes an occupancy count.
package rvc_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // A count must represent 0..depth inclusive, hence depth+1 codes.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rvc_ram.sv
// FIFO storage: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
module rvc_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rvc_fifo.sv
// First-word fall-through FIFO with a registered in_ready and an occupancy counter.
module rvc_fifo
  import rvc_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = DEPTH - 1,
  localparam int CW       = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int AW = clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q;
  logic          push, pop;

  assign push = in_valid & rdy_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // in_ready looks at the post-edge count, so a pop while full frees the slot
  // only for the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      rdy_q   <= (count_d < CW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  rvc_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  assign in_ready    = rdy_q;
  assign out_valid   = (count_q != '0);
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_rvc_fifo.sv
// Directed bench for rvc_fifo with a queue-based reference model checked every cycle.
module tb_rvc_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 1;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush, in_valid, in_ready, out_valid, out_ready, almost_full;
  logic [WIDTH-1:0] in_data, out_data;
  logic [CW-1:0]    count;

  int n_run  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_rdy = 1'b1;

  rvc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after posedge, so at negedge they are exactly what the
  // next posedge samples: compare first, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        m_rdy = 1'b1;
      end
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("m_count", {29'd0, count}, mq.size());
      chk("m_almost_full", {31'd0, almost_full}, {31'd0, mq.size() >= AF});
      if (mq.size() != 0) chk("m_out_data", {24'd0, out_data}, {24'd0, mq[0]});
      if (!rst) begin
        if (flush) begin
          mq.delete();
          m_rdy = 1'b1;
        end else begin
          automatic bit p = in_valid && m_rdy;
          automatic bit q = out_ready && (mq.size() != 0);
          if (q) void'(mq.pop_front());
          if (p) mq.push_back(in_data);
          m_rdy = (mq.size() < DEPTH);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] fill [4];
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};
    flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    #1 rst = 1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_almost_full", {31'd0, almost_full}, 0);
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("idle_count", {29'd0, count}, 0);

    // Fill with consumer stalled.
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = fill[i];
      cyc();
      chk("fill_count", {29'd0, count}, i + 1);
      chk("fill_af", {31'd0, almost_full}, {31'd0, i >= 2});
      chk("fill_ready", {31'd0, in_ready}, {31'd0, i < 3});
    end
    in_data = 8'h55;
    cyc();
    chk("overfill_count", {29'd0, count}, 4);
    chk("overfill_head", {24'd0, out_data}, 32'h11);
    in_valid = 0;

    // Drain in order.
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", {24'd0, out_data}, {24'd0, fill[i]});
      cyc();
    end
    chk("drain_out_valid", {31'd0, out_valid}, 0);
    chk("drain_in_ready", {31'd0, in_ready}, 1);

    // Streaming through pointer wrap.
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = WIDTH'(i);
      if (i > 0) chk("stream_data", {24'd0, out_data}, i - 1);
      cyc();
      chk("stream_count", {29'd0, count}, 1);
    end
    in_valid = 0;
    chk("stream_last", {24'd0, out_data}, 9);
    cyc();
    chk("stream_empty", {29'd0, count}, 0);
    out_ready = 0;

    // Full with simultaneous pop: pop only, then push+pop.
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + WIDTH'(i);
      cyc();
    end
    chk("full2_count", {29'd0, count}, 4);
    in_data = 8'hB0; out_ready = 1;
    cyc();
    chk("fullpop_count", {29'd0, count}, 3);
    chk("fullpop_ready", {31'd0, in_ready}, 1);
    chk("fullpop_head", {24'd0, out_data}, 32'hA1);
    in_data = 8'hB1;
    cyc();
    chk("pushpop_count", {29'd0, count}, 3);
    chk("pushpop_head", {24'd0, out_data}, 32'hA2);

    // Head held while stalled.
    in_valid = 0; out_ready = 0;
    cyc(); cyc();
    chk("stall_head", {24'd0, out_data}, 32'hA2);

    // Flush at count 2 with a push and pop offered.
    out_ready = 1;
    cyc();
    chk("preflush_count", {29'd0, count}, 2);
    flush = 1; in_valid = 1; in_data = 8'hC0;
    cyc();
    chk("flush_count", {29'd0, count}, 0);
    chk("flush_out_valid", {31'd0, out_valid}, 0);
    chk("flush_in_ready", {31'd0, in_ready}, 1);
    flush = 0; out_ready = 0;

    // Asynchronous reset mid-stream at count 2.
    in_data = 8'h5A; cyc();
    in_data = 8'h5B; cyc();
    chk("prerst_count", {29'd0, count}, 2);
    in_data = 8'h77;
    #2 rst = 1;
    #1;
    chk("arst_count", {29'd0, count}, 0);
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 1);
    chk("arst_af", {31'd0, almost_full}, 0);
    cyc();
    rst = 0;
    cyc();
    chk("postrst_count", {29'd0, count}, 1);
    chk("postrst_data", {24'd0, out_data}, 32'h77);
    in_valid = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rvc_fifo.md
RVC_FIFO -- requirements
Module: rvc_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload bits per entry.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; power of two, at least 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: occupancy at which almost_full asserts; range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of all entries.
REQ-007 SHALL have port in_valid, input, 1 bit: producer offers in_data.
REQ-008 SHALL have port in_ready, output, 1 bit: registered; space available.
REQ-009 SHALL have port in_data, input, WIDTH bits: producer payload.
REQ-010 SHALL have port out_valid, output, 1 bit: head entry present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts head.
REQ-012 SHALL have port out_data, output, WIDTH bits: head payload.
REQ-013 SHALL have port count, output, CW = clog2(DEPTH+1) bits: current occupancy.
REQ-014 SHALL have port almost_full, output, 1 bit: asserted while count >= AF_LEVEL.

Function
REQ-015 SHALL push in_data at the tail on any rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL pop the head on any rising edge where out_valid and out_ready are both 1.
REQ-017 SHALL drive in_ready from a flop, never combinationally from out_ready or in_valid; next value = (next count < DEPTH).
REQ-018 SHALL drive out_valid = (count != 0) and out_data = head entry (first-word fall-through); an entry pushed into an empty FIFO appears one cycle after its push edge.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers; this applies at any occupancy 1..DEPTH-1.
REQ-020 SHALL, when full (count = DEPTH), hold in_ready = 0 so no push occurs even if a pop happens that edge; in_ready returns to 1 on the following edge.
REQ-021 SHALL, when empty, make out_data don't-care and perform no pop regardless of out_ready.
REQ-022 SHALL wrap read and write pointers modulo DEPTH using log2(DEPTH)-bit counters with no special case.
REQ-023 SHALL, on flush = 1 at an edge, set count = 0 and pointers = 0, ignore any push or pop that edge, and leave in_ready = 1 and out_valid = 0 afterwards.
REQ-024 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL never overflow, underflow, or change count by more than 1 per cycle.

Reset
REQ-026 SHALL, while rst = 1, immediately force count = 0, pointers = 0, in_ready = 1, out_valid = 0, almost_full = 0; storage contents are not reset.
REQ-027 SHALL, if rst asserts mid-stream, discard all entries; the first edge after deassertion accepts a push normally.

Structure
REQ-028 SHALL take the clog2 helper function and the CW width rule from the shared rvc_pkg package, which other rvc blocks use.
REQ-029 SHALL place storage in one sub-module, rvc_ram: a DEPTH x WIDTH array with one synchronous write port and one asynchronous read port.
REQ-030 SHALL keep control (pointers, count, in_ready flop) in rvc_fifo.

Verification
REQ-031 Reset then idle, WIDTH=8, DEPTH=4: rst pulse -> in_ready=1, out_valid=0, count=0, almost_full=0.
REQ-032 Fill: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count 1,2,3,4; almost_full from count 3; in_ready=0 after the 4th push; a 5th in_valid is not accepted.
REQ-033 Drain order: from full, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on successive cycles; then out_valid=0, in_ready=1.
REQ-034 Streaming with wrap-around: in_valid=out_ready=1 for 10 cycles with incrementing data 0..9 -> count steady at 1 after the first cycle; output sequence 0..9 with no gaps.
REQ-035 Full plus simultaneous pop: at count=4 with in_valid=1 and out_ready=1 -> that edge pops only (count=3); next edge pushes and pops (count stays 3).
REQ-036 Flush and reset mid-stream: at count=2, flush=1 with in_valid=1 -> count=0, out_valid=0; repeat with rst instead -> same result, asynchronous to clk.
